// File: rtl/mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default memory map,
// FSM state encoding, response source tags and the write-sections decoder.
package mem_pkg;

    localparam logic [31:0] PROGRAM_MEMORY_SIZE = 32'h0000_1000;
    localparam logic [31:0] LED_ADDR            = 32'h0000_2000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Where the response word comes from during RESP.
    typedef enum logic [1:0] {
        SRC_RAM  = 2'd0,
        SRC_ZERO = 2'd1,
        SRC_LED  = 2'd2
    } rsrc_t;

    // Port identifiers used by the round-robin tie-break.
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    // bit0 -> byte0, bit1 -> byte1, bit2 -> bytes 2 and 3.
    function automatic logic [3:0] sections_to_be(input logic [2:0] sections);
        return {sections[2], sections[2], sections[1], sections[0]};
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin tie-break: req[0] = fetch, req[1] = data.
// On a tie the port not named by 'last' wins; otherwise the lone requester.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // Pick the winner; the value is meaningful only when some req is high.
    always_comb begin
        if (&req) begin
            grant = ~last;
        end else begin
            grant = req[1] ? GRANT_D : GRANT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch port
// and a data port. Each access takes IDLE -> ACC -> RESP (one cycle each).
// Optional LED register at LED_ADDR: define MEM_ARBITER_LED_MMIO_EN.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] PROGRAM_MEMORY_SIZE = mem_pkg::PROGRAM_MEMORY_SIZE,
    parameter logic [31:0] LED_ADDR            = mem_pkg::LED_ADDR
) (
    input  logic        clk48,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_write_sections,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        led_on
);

`ifdef MEM_ARBITER_LED_MMIO_EN
    localparam logic LED_EN = 1'b1;
`else
    localparam logic LED_EN = 1'b0;
`endif

    state_t      state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        led_hit_q;
    logic        fault_pend_q;
    rsrc_t       rsrc_q;
    logic        ram_en_q;
    logic [3:0]  ram_we_q;
    logic        if_ready_q;
    logic        d_ready_q;
    logic        d_fault_q;
    logic        led_q;

    logic        arb_grant;
    logic [31:0] sel_addr;
    logic        sel_in_ram;
    logic        sel_is_led;

    rr_arbiter2 u_arb (
        .req   ({d_req, if_req}),
        .last  (last_grant_q),
        .grant (arb_grant)
    );

    // Decode the address of whichever port the arbiter would grant now.
    always_comb begin
        sel_addr   = (arb_grant == GRANT_D) ? d_addr : if_addr;
        sel_in_ram = (sel_addr < PROGRAM_MEMORY_SIZE);
        sel_is_led = LED_EN && (arb_grant == GRANT_D) &&
                     (sel_addr[31:2] == LED_ADDR[31:2]);
    end

    // Access FSM; RAM strobes, ready and fault are all registered here.
    always_ff @(posedge clk48) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            gnt_q        <= GRANT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            led_hit_q    <= 1'b0;
            fault_pend_q <= 1'b0;
            rsrc_q       <= SRC_ZERO;
            ram_en_q     <= 1'b0;
            ram_we_q     <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            d_fault_q    <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        gnt_q        <= arb_grant;
                        last_grant_q <= arb_grant;
                        addr_q       <= sel_addr[31:2];
                        wdata_q      <= d_wdata;
                        be_q         <= (arb_grant == GRANT_D) ?
                                        sections_to_be(d_write_sections) : '0;
                        led_hit_q    <= sel_is_led;
                        fault_pend_q <= (arb_grant == GRANT_D) && !sel_in_ram && !sel_is_led;
                        ram_en_q     <= sel_in_ram && !sel_is_led;
                        ram_we_q     <= ((arb_grant == GRANT_D) && sel_in_ram && !sel_is_led) ?
                                        sections_to_be(d_write_sections) : '0;
                        rsrc_q       <= sel_is_led ? SRC_LED :
                                        (sel_in_ram ? SRC_RAM : SRC_ZERO);
                        state_q      <= (arb_grant == GRANT_D) ? D_ACC : IF_ACC;
                    end
                end
                IF_ACC, D_ACC: begin
                    ram_en_q   <= 1'b0;
                    ram_we_q   <= '0;
                    if (led_hit_q && (be_q != '0)) begin
                        led_q <= (wdata_q != '0);
                    end
                    if_ready_q <= (gnt_q == GRANT_IF);
                    d_ready_q  <= (gnt_q == GRANT_D);
                    d_fault_q  <= fault_pend_q;
                    state_q    <= RESP;
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    d_fault_q  <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM data arrives one cycle after the strobe, i.e. during RESP, so the
    // read words are steered combinationally and forced to zero otherwise.
    always_comb begin
        if_rdata = '0;
        d_rdata  = '0;
        if (if_ready_q && (rsrc_q == SRC_RAM)) begin
            if_rdata = ram_rdata;
        end
        if (d_ready_q) begin
            case (rsrc_q)
                SRC_RAM: d_rdata = ram_rdata;
                SRC_LED: d_rdata = {31'b0, led_q};
                default: d_rdata = '0;
            endcase
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign d_fault   = d_fault_q;
    assign led_on    = led_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle synchronous RAM model.
// LED checks follow MEM_ARBITER_LED_MMIO_EN as the DUT does.
module tb_mem_arbiter;

    logic        clk48 = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_write_sections;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_fault;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        led_on;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int cnt0;

    // Preload path into the RAM model, so only one process writes mem.
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:1023];

    always #5 clk48 = ~clk48;

    mem_arbiter dut (
        .clk48            (clk48),
        .reset_n          (reset_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_ready         (if_ready),
        .if_rdata         (if_rdata),
        .d_req            (d_req),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_write_sections (d_write_sections),
        .d_ready          (d_ready),
        .d_rdata          (d_rdata),
        .d_fault          (d_fault),
        .ram_en           (ram_en),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .led_on           (led_on)
    );

    // Synchronous single-port RAM model plus strobe counter.
    always @(posedge clk48) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (ram_en) begin
            en_cnt    <= en_cnt + 1;
            ram_rdata <= mem[ram_addr[9:0]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr[9:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_write_sections = '0;
        tick(); tick();

        // Reset state
        chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
        chk("rst_d_ready",  {31'b0, d_ready},  32'd0);
        chk("rst_d_fault",  {31'b0, d_fault},  32'd0);
        chk("rst_ram_en",   {31'b0, ram_en},   32'd0);
        chk("rst_ram_we",   {28'b0, ram_we},   32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata",  d_rdata,  32'd0);
        chk("rst_led_on",   {31'b0, led_on},   32'd0);
        reset_n = 1'b1;

        preload(10'd4, 32'hDEAD_BEEF);
        preload(10'd5, 32'hCAFE_F00D);
        preload(10'd6, 32'h1234_5678);
        preload(10'd8, 32'hAABB_CCDD);

        // Fetch only from 0x10
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("f1_ram_en",   {31'b0, ram_en}, 32'd1);
        chk("f1_ram_we",   {28'b0, ram_we}, 32'd0);
        chk("f1_ram_addr", {2'b0, ram_addr}, 32'h4);
        chk("f1_no_ready", {31'b0, if_ready}, 32'd0);
        tick();
        chk("f1_if_ready", {31'b0, if_ready}, 32'd1);
        chk("f1_if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("f1_d_ready",  {31'b0, d_ready}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("f1_ready_drop", {31'b0, if_ready}, 32'd0);
        chk("f1_rdata_zero", if_rdata, 32'd0);

        // Simultaneous requests after reset: data first, fetch 3 cycles later
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h18;
        d_req = 1'b1; d_addr = 32'h14; d_write_sections = 3'b000;
        tick();
        chk("tie_d_addr", {2'b0, ram_addr}, 32'h5);
        tick();
        chk("tie_d_ready",  {31'b0, d_ready},  32'd1);
        chk("tie_d_rdata",  d_rdata, 32'hCAFE_F00D);
        chk("tie_if_wait",  {31'b0, if_ready}, 32'd0);
        d_req = 1'b0;
        tick();
        chk("tie_idle_rdy", {31'b0, if_ready}, 32'd0);
        tick();
        chk("tie_f_addr",   {2'b0, ram_addr}, 32'h6);
        chk("tie_f_norady", {31'b0, if_ready}, 32'd0);
        tick();
        chk("tie_if_ready", {31'b0, if_ready}, 32'd1);
        chk("tie_if_rdata", if_rdata, 32'h1234_5678);
        if_req = 1'b0;
        tick();

        // Partial write, sections 101 to 0x20
        d_req = 1'b1; d_addr = 32'h20; d_wdata = 32'h1122_3344; d_write_sections = 3'b101;
        tick();
        chk("wr_ram_en",    {31'b0, ram_en}, 32'd1);
        chk("wr_ram_we",    {28'b0, ram_we}, 32'hD);
        chk("wr_ram_addr",  {2'b0, ram_addr}, 32'h8);
        chk("wr_ram_wdata", ram_wdata, 32'h1122_3344);
        tick();
        chk("wr_d_ready",   {31'b0, d_ready}, 32'd1);
        chk("wr_d_fault",   {31'b0, d_fault}, 32'd0);
        d_req = 1'b0; d_write_sections = 3'b000;
        tick();
        chk("wr_mem_word",  mem[8], 32'h1122_CC44);

        // Out-of-range data read at 0x1000
        cnt0 = en_cnt;
        d_req = 1'b1; d_addr = 32'h1000;
        tick();
        chk("oor_ram_en",  {31'b0, ram_en}, 32'd0);
        tick();
        chk("oor_d_ready", {31'b0, d_ready}, 32'd1);
        chk("oor_d_fault", {31'b0, d_fault}, 32'd1);
        chk("oor_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        chk("oor_fault_drop", {31'b0, d_fault}, 32'd0);
        chk("oor_no_strobe",  en_cnt - cnt0, 32'd0);

        // Out-of-range fetch at 0x3000: zero data, no fault
        if_req = 1'b1; if_addr = 32'h3000;
        tick();
        chk("foor_ram_en",   {31'b0, ram_en}, 32'd0);
        tick();
        chk("foor_if_ready", {31'b0, if_ready}, 32'd1);
        chk("foor_if_rdata", if_rdata, 32'd0);
        chk("foor_d_fault",  {31'b0, d_fault}, 32'd0);
        if_req = 1'b0;
        tick();

        // LED register at 0x2000
        d_req = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1; d_write_sections = 3'b001;
        tick();
        chk("led_w1_ram_en", {31'b0, ram_en}, 32'd0);
        tick();
        chk("led_w1_ready",  {31'b0, d_ready}, 32'd1);
`ifdef MEM_ARBITER_LED_MMIO_EN
        chk("led_w1_fault",  {31'b0, d_fault}, 32'd0);
        chk("led_w1_on",     {31'b0, led_on},  32'd1);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_write_sections = 3'b000;
        tick(); tick();
        chk("led_rd_ready",  {31'b0, d_ready}, 32'd1);
        chk("led_rd_rdata",  d_rdata, 32'd1);
        chk("led_rd_fault",  {31'b0, d_fault}, 32'd0);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_wdata = 32'h0; d_write_sections = 3'b001;
        tick(); tick();
        chk("led_w0_ready",  {31'b0, d_ready}, 32'd1);
        chk("led_w0_on",     {31'b0, led_on},  32'd0);
`else
        chk("led_off_fault", {31'b0, d_fault}, 32'd1);
        chk("led_off_on",    {31'b0, led_on},  32'd0);
`endif
        d_req = 1'b0; d_write_sections = 3'b000;
        tick();

        // Reset during D_ACC aborts the access
        d_req = 1'b1; d_addr = 32'h24; d_wdata = 32'h55; d_write_sections = 3'b111;
        tick();
        chk("abort_in_acc", {31'b0, ram_en}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk("abort_no_ready", {31'b0, d_ready}, 32'd0);
        chk("abort_ram_en",   {31'b0, ram_en},  32'd0);
        reset_n = 1'b1; d_req = 1'b0; d_write_sections = 3'b000;
        tick();
        chk("abort_still_no_ready", {31'b0, d_ready}, 32'd0);
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("abort_idle_fetch_acc", {31'b0, ram_en}, 32'd1);
        tick();
        chk("abort_fetch_ready", {31'b0, if_ready}, 32'd1);
        chk("abort_fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        if_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: PROGRAM_MEMORY_SIZE, default 32'h1000, RAM size in bytes (power of two, multiple of 4).
REQ-002 Parameter: LED_ADDR, default 32'h0000_2000, byte address of LED register (used only with MEM_ARBITER_LED_MMIO_EN).
REQ-003 Ports, one per line, as name  direction  width  meaning:
- clk48  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset
- if_req  in  1  instruction fetch request, held until if_ready
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetch word, valid with if_ready
- d_req  in  1  data request, held until d_ready
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_write_sections  in  3  bit0 = byte0, bit1 = byte1, bit2 = bytes 2+3; 0 = read
- d_ready  out  1  one-cycle data completion pulse
- d_rdata  out  32  read word, valid with d_ready
- d_fault  out  1  out-of-range access flag, valid with d_ready
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte write enables
- ram_addr  out  30  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, 1-cycle synchronous latency
- led_on  out  1  LED register state

Function
REQ-004 The block SHALL share one single-port RAM between fetch and data ports using FSM states IDLE, IF_ACC, D_ACC, RESP.
REQ-005 In IDLE, with exactly one request high, the block SHALL latch that port's address, data and sections, and move to IF_ACC or D_ACC.
REQ-006 With both requests high in IDLE, the block SHALL grant the port not recorded in last_grant, then update last_grant; after reset, last_grant SHALL favour data.
REQ-007 IF_ACC/D_ACC SHALL last exactly one cycle, asserting ram_en = 1 and ram_addr = latched addr[31:2]; ram_we = 0 in IF_ACC, and ram_we = {s[2], s[2], s[1], s[0]} in D_ACC.
REQ-008 RESP SHALL last exactly one cycle, pulse the granted port's ready, drive its rdata from ram_rdata, and then return to IDLE.
REQ-009 Request-to-ready latency SHALL be 3 cycles with no contention; throughput SHALL be one access per 3 cycles.
REQ-010 addr[1:0] SHALL be ignored; all accesses are word-aligned.
REQ-011 A data access with addr >= PROGRAM_MEMORY_SIZE, other than LED_ADDR when enabled, SHALL hold ram_en = 0, drop writes, return d_rdata = 0 and assert d_fault with d_ready.
REQ-012 Fetch beyond PROGRAM_MEMORY_SIZE SHALL return if_rdata = 0 with ram_en = 0, and SHALL NOT fault.
REQ-013 Requests arriving outside IDLE SHALL wait; a request deasserted before ready is a protocol violation and its behaviour is undefined.
REQ-014 When not in RESP, the ready outputs SHALL be 0; rdata values outside ready cycles are don't-care but SHALL be 0 in simulation.

Reset
REQ-015 With reset_n low at a clk48 edge, the block SHALL set: state = IDLE, last_grant = fetch (data wins first tie), all ready/fault/ram_en/ram_we = 0, rdata = 0, led_on = 0.
REQ-016 Reset during an ACC or RESP state SHALL abort the access with no ready pulse; a RAM write already strobed is not undone.

Configuration
REQ-017 With MEM_ARBITER_LED_MMIO_EN defined:
- a data write to LED_ADDR with nonzero sections SHALL set led_on <= (d_wdata != 0) at the D_ACC edge, with ram_en = 0;
- a read of LED_ADDR SHALL return {31'b0, led_on};
- neither access faults.
REQ-018 With MEM_ARBITER_LED_MMIO_EN undefined, led_on SHALL be tied to 0 and LED_ADDR SHALL receive no special decode.

Structure
REQ-019 A shared package mem_pkg SHALL hold PROGRAM_MEMORY_SIZE, LED_ADDR, the state enum and the write-sections-to-byte-enable function.
REQ-020 The tie-break logic SHALL live in one sub-module, rr_arbiter2, with inputs req[1:0] and last, and output grant.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Fetch only, if_addr = 0x10, RAM word 0xDEADBEEF -> if_ready 3 cycles later, if_rdata = 0xDEADBEEF, ram_we = 0.
- Simultaneous if_req and d_req after reset, both held -> data served first; fetch ready 3 cycles after d_ready.
- Data write, sections 3'b101, addr 0x20, wdata 0x11223344 -> ram_we = 4'b1101, ram_addr = 0x8.
- d_addr = 0x1000 read -> d_ready with d_fault = 1, d_rdata = 0, ram_en never high.
- LED enabled, write 1 to 0x2000, then read 0x2000 -> led_on = 1, d_rdata = 1; write 0 -> led_on = 0.
- reset_n low during D_ACC -> no d_ready; state IDLE on the next cycle.
